// File: rtl/i2s_level_detector.sv
// Drains PCM words from the I2S receive FIFO and reports the per-window mean |sample|,
// the peak |sample| and a hysteresis activity flag once per power-of-two window.
module i2s_level_detector #(
   parameter int unsigned DW           = 32,
   parameter int unsigned MAX_WIN_LOG2 = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          fifo_empty,
   input  logic [DW-1:0] fifo_rdata,
   output logic          fifo_rd,
   input  logic [3:0]    window_log2,
   input  logic [DW-1:0] th_hi,
   input  logic [DW-1:0] th_lo,
   output logic [DW-1:0] level,
   output logic [DW-1:0] peak,
   output logic          active,
   output logic          win_done
);

   localparam int unsigned AW   = DW + MAX_WIN_LOG2;
   localparam int unsigned CW   = MAX_WIN_LOG2 + 1;
   localparam logic [3:0]  WMAX = 4'(MAX_WIN_LOG2);
   localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};

   typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

   state_t        state_q;
   logic [AW-1:0] acc_q;
   logic [CW-1:0] cnt_q;
   logic [DW-1:0] peak_acc_q;
   logic [DW-1:0] s_q;
   logic          s_vld_q;
   logic [3:0]    win_log2_q;
   logic [DW-1:0] level_q;
   logic [DW-1:0] peak_q;
   logic          active_q;
   logic          win_done_q;

   logic [3:0]    win_clamp_c;
   logic [CW-1:0] cnt_last_c;
   logic          last_c;
   logic [DW-1:0] abs_c;
   logic [AW-1:0] acc_sum_c;
   logic [DW-1:0] peak_max_c;
   logic [DW-1:0] level_new_c;
   logic          active_new_c;

   // Window bookkeeping, saturating magnitude and report values
   always_comb begin
      win_clamp_c  = (window_log2 > WMAX) ? WMAX : window_log2;
      cnt_last_c   = CW'((CW'(1) << win_log2_q) - CW'(1));
      last_c       = s_vld_q && (cnt_q == cnt_last_c);
      fifo_rd      = rst_n && en && (state_q == RUN) && !fifo_empty && !last_c;
      abs_c        = s_q;
      if (s_q[DW-1]) begin
         abs_c = (s_q == SMIN) ? SMAX : DW'(-s_q);
      end
      acc_sum_c    = acc_q + AW'(abs_c);
      peak_max_c   = (abs_c > peak_acc_q) ? abs_c : peak_acc_q;
      level_new_c  = DW'(acc_q >> win_log2_q);
      active_new_c = active_q;
      if (level_new_c > th_hi) begin
         active_new_c = 1'b1;
      end else if (level_new_c < th_lo) begin
         active_new_c = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         peak_acc_q <= '0;
         s_q        <= '0;
         s_vld_q    <= 1'b0;
         win_log2_q <= '0;
         level_q    <= '0;
         peak_q     <= '0;
         active_q   <= 1'b0;
         win_done_q <= 1'b0;
      end else begin
         win_done_q <= 1'b0;
         s_vld_q    <= fifo_rd;
         if (fifo_rd) begin
            s_q <= fifo_rdata;
         end
         case (state_q)
            IDLE: begin
               if (en) begin
                  state_q    <= RUN;
                  win_log2_q <= win_clamp_c;
               end
            end
            RUN: begin
               // Dropping en abandons the partial window; reported outputs are held
               if (!en) begin
                  state_q    <= IDLE;
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  peak_acc_q <= '0;
               end else if (s_vld_q) begin
                  acc_q      <= acc_sum_c;
                  peak_acc_q <= peak_max_c;
                  cnt_q      <= cnt_q + CW'(1);
                  if (last_c) begin
                     state_q <= REPORT;
                  end
               end
            end
            REPORT: begin
               level_q    <= level_new_c;
               peak_q     <= peak_acc_q;
               active_q   <= active_new_c;
               win_done_q <= 1'b1;
               acc_q      <= '0;
               cnt_q      <= '0;
               peak_acc_q <= '0;
               if (en) begin
                  state_q    <= RUN;
                  win_log2_q <= win_clamp_c;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign level    = level_q;
   assign peak     = peak_q;
   assign active   = active_q;
   assign win_done = win_done_q;

endmodule

// File: tb/tb_i2s_level_detector.sv
// Bench for i2s_level_detector: queue-backed FIFO, window-level reference model and
// a win_done-driven scoreboard monitor.
module tb_i2s_level_detector;

   typedef struct packed {
      logic [31:0] lvl;
      logic [31:0] pk;
      logic        act;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        fifo_empty;
   logic [31:0] fifo_rdata;
   logic        fifo_rd;
   logic [3:0]  window_log2;
   logic [31:0] th_hi;
   logic [31:0] th_lo;
   logic [31:0] level;
   logic [31:0] peak;
   logic        active;
   logic        win_done;

   logic [31:0] fq[$];
   exp_t        expq[$];
   longint      wbuf[$];
   int          mlog;
   bit          m_active;
   int          pop_cnt;
   int          errors;
   int          checks;

   i2s_level_detector #(.DW(32), .MAX_WIN_LOG2(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_rd    (fifo_rd),
      .window_log2(window_log2),
      .th_hi      (th_hi),
      .th_lo      (th_lo),
      .level      (level),
      .peak       (peak),
      .active     (active),
      .win_done   (win_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic refresh();
      fifo_empty = (fq.size() == 0);
      fifo_rdata = fifo_empty ? 32'h0 : fq[0];
   endtask

   // One clock: the pop decision is taken from fifo_rd as seen before the edge
   task automatic tick();
      bit rd_s;
      @(negedge clk);
      rd_s = fifo_rd;
      @(posedge clk);
      if (rd_s) begin
         if (fq.size() > 0) void'(fq.pop_front());
         pop_cnt++;
      end
      #1;
      refresh();
   endtask

   // Reference: windows of 2^mlog magnitudes -> mean, max, hysteresis flag
   task automatic model_add(input logic [31:0] s);
      longint a;
      longint sum;
      longint pk;
      longint lvl;
      exp_t   e;
      a = longint'(int'(s));
      if (a < 0) a = -a;
      if (a > 64'sh7FFF_FFFF) a = 64'sh7FFF_FFFF;
      wbuf.push_back(a);
      if (wbuf.size() == (1 << mlog)) begin
         sum = 0;
         pk  = 0;
         foreach (wbuf[i]) begin
            sum += wbuf[i];
            if (wbuf[i] > pk) pk = wbuf[i];
         end
         lvl = sum / longint'(wbuf.size());
         if (lvl > longint'(th_hi)) m_active = 1'b1;
         else if (lvl < longint'(th_lo)) m_active = 1'b0;
         e.lvl = 32'(lvl);
         e.pk  = 32'(pk);
         e.act = m_active;
         expq.push_back(e);
         wbuf.delete();
      end
   endtask

   task automatic push(input logic [31:0] s, input int gap);
      fq.push_back(s);
      refresh();
      model_add(s);
      repeat (gap) tick();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (fq.size() != 0 && n < 3000) begin
         tick();
         n++;
      end
      if (fq.size() != 0) chk("drain_timeout", 32'(fq.size()), 32'd0);
      repeat (4) tick();
   endtask

   // Leave RUN, pick a new window size, restart
   task automatic restart(input logic [3:0] wl);
      en = 1'b0;
      wbuf.delete();
      repeat (3) tick();
      window_log2 = wl;
      mlog = (wl > 4'd8) ? 8 : int'(wl);
      en = 1'b1;
      tick();
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (fifo_empty) chk("fifo_rd_when_empty", 32'(fifo_rd), 32'd0);
         if (win_done) begin
            if (expq.size() == 0) begin
               chk("unexpected_win_done", 32'(win_done), 32'd0);
            end else begin
               e = expq.pop_front();
               chk("sb_level", level, e.lvl);
               chk("sb_peak", peak, e.pk);
               chk("sb_active", 32'(active), 32'(e.act));
            end
         end
      end
   endtask

   initial begin
      logic [31:0] s;
      int          n;
      errors = 0; checks = 0; pop_cnt = 0; mlog = 0; m_active = 1'b0;
      rst_n = 1'b0; en = 1'b0; window_log2 = 4'd0; th_hi = 32'd20; th_lo = 32'd5;
      refresh();
      fork
         monitor();
      join_none
      repeat (3) tick();
      chk("rst_level", level, 32'd0);
      chk("rst_peak", peak, 32'd0);
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_win_done", 32'(win_done), 32'd0);
      rst_n = 1'b1;
      tick();

      // Basic mean / peak / activity set
      restart(4'd2);
      push(32'd10, 0); push(-32'sd20, 1); push(32'd30, 0); push(-32'sd40, 2);
      drain();
      chk("t1_level", level, 32'd25);
      chk("t1_peak", peak, 32'd40);
      chk("t1_active", 32'(active), 32'd1);

      // Hysteresis clear, set, and hold in the dead band
      push(32'd1, 0); push(-32'sd1, 0); push(32'd2, 3); push(-32'sd2, 0);
      drain();
      chk("t2_level", level, 32'd1);
      chk("t2_active_clr", 32'(active), 32'd0);
      repeat (4) push(32'd50, 0);
      repeat (4) push(32'd10, 1);
      drain();
      chk("t2_level_hold", level, 32'd10);
      chk("t2_active_hold", 32'(active), 32'd1);

      // Most negative sample saturates; one-sample windows
      restart(4'd0);
      repeat (3) push(32'h8000_0000, 0);
      drain();
      chk("t3_level", level, 32'h7FFF_FFFF);
      chk("t3_peak", peak, 32'h7FFF_FFFF);
      push(-32'sd7, 2); push(32'd3, 0);
      drain();

      // Oversized window_log2 clamps to 256; back-to-back pops
      en = 1'b0;
      wbuf.delete();
      repeat (3) tick();
      window_log2 = 4'd15;
      mlog = 8;
      repeat (256) begin
         fq.push_back(32'h7FFF_FFFF);
         model_add(32'h7FFF_FFFF);
      end
      refresh();
      pop_cnt = 0;
      en = 1'b1;
      n = 0;
      while (pop_cnt == 0 && n < 20) begin
         tick();
         n++;
      end
      repeat (256) tick();
      chk("t4_pops_in_257", 32'(pop_cnt), 32'd256);
      drain();
      chk("t4_level", level, 32'h7FFF_FFFF);

      // Partial window discarded by en drop; no pops while disabled
      restart(4'd2);
      push(32'd100, 0); push(32'd200, 0); push(32'd300, 0);
      drain();
      en = 1'b0;
      wbuf.delete();
      repeat (2) tick();
      repeat (4) push(32'd4, 0);
      pop_cnt = 0;
      repeat (5) tick();
      chk("t5_no_pop_disabled", 32'(pop_cnt), 32'd0);
      en = 1'b1;
      drain();
      chk("t5_level", level, 32'd4);
      chk("t5_peak", peak, 32'd4);

      // Randomized windows, thresholds and FIFO gaps
      for (int r = 0; r < 10; r++) begin
         th_hi = 32'($urandom_range(0, 120));
         th_lo = 32'($urandom_range(0, 120));
         restart((r == 6) ? 4'd12 : 4'($urandom_range(0, 3)));
         n = (1 << mlog) * int'($urandom_range(1, 3)) + int'($urandom_range(0, 1));
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 5) == 0) s = $urandom;
            else s = 32'($urandom_range(0, 240)) - 32'd120;
            push(s, int'($urandom_range(0, 2)));
         end
         drain();
      end

      // Reset mid-window with the FIFO empty
      th_hi = 32'd20; th_lo = 32'd5;
      restart(4'd2);
      push(32'd90, 0); push(32'd90, 0);
      drain();
      rst_n = 1'b0;
      wbuf.delete();
      m_active = 1'b0;
      repeat (2) tick();
      chk("t6_level", level, 32'd0);
      chk("t6_peak", peak, 32'd0);
      chk("t6_active", 32'(active), 32'd0);
      chk("t6_fifo_rd", 32'(fifo_rd), 32'd0);
      rst_n = 1'b1;
      tick();
      push(32'd3, 0); push(-32'sd9, 1); push(32'd6, 0); push(32'd2, 0);
      drain();

      repeat (5) tick();
      chk("exp_queue_empty", 32'(expq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
